// File: rtl/ip_vdp_bridge_pkg.sv
// Shared constants and types for the MSX bus to V9958 bridge.
package ip_vdp_bridge_pkg;

    localparam logic [7:0] VDP_IO_BASE    = 8'h98;
    localparam int         VDP_FIFO_DEPTH = 4;
    localparam int         VDP_FIFO_AW    = 2;
    localparam int         VDP_FIFO_DW    = 10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_GAP      = 2'd2
    } vdp_state_e;

    // Only the port-select bits above the two register-select bits are decoded.
    function automatic logic io_hit(input logic [7:0] addr, input logic [7:0] base);
        return addr[7:2] == base[7:2];
    endfunction

endpackage

// File: rtl/ip_vdp_bridge_fifo.sv
// 4-entry write FIFO holding {port[1:0], data[7:0]} with show-ahead head output.
module ip_vdp_bridge_fifo
    import ip_vdp_bridge_pkg::*;
(
    input  logic                   clk,
    input  logic                   n_reset,
    input  logic                   push,
    input  logic [VDP_FIFO_DW-1:0] push_data,
    input  logic                   pop,
    output logic [VDP_FIFO_DW-1:0] head,
    output logic                   full,
    output logic                   empty
);

    logic [VDP_FIFO_DW-1:0] mem_q [VDP_FIFO_DEPTH];
    logic [VDP_FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [VDP_FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0]             count_q, count_d;
    logic                   do_push, do_pop;

    // A push into a full FIFO is still legal when the head leaves in the same cycle.
    assign do_pop  = pop & (count_q != 3'd0);
    assign do_push = push & ((count_q != 3'(VDP_FIFO_DEPTH)) | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 2'd1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 3'd1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == 3'(VDP_FIFO_DEPTH));
    assign empty = (count_q == 3'd0);

endmodule

// File: rtl/ip_vdp_bridge.sv
// MSX I/O to V9958 bridge: decodes VDP ports, queues writes, serialises
// accesses onto the VDP req/ack handshake and returns read data to the bus.
module ip_vdp_bridge
    import ip_vdp_bridge_pkg::*;
#(
    parameter logic [7:0] IO_BASE = VDP_IO_BASE
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] bus_address,
    input  logic        bus_io_read,
    input  logic        bus_io_write,
    input  logic [7:0]  bus_write_data,
    output logic        bus_read_ready,
    output logic [7:0]  bus_read_data,
    input  logic        initial_busy,
    output logic        req,
    input  logic        ack,
    output logic        wrt,
    output logic [1:0]  address,
    output logic [7:0]  wdata,
    input  logic [7:0]  rdata,
    output logic        fifo_overflow
);

    vdp_state_e state_q, state_d;
    logic       req_q, req_d;
    logic       wrt_q, wrt_d;
    logic [1:0] address_q, address_d;
    logic [7:0] wdata_q, wdata_d;
    logic       ready_q, ready_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       ovf_q, ovf_d;
    logic       pend_q, pend_d;
    logic [1:0] pend_addr_q, pend_addr_d;

    logic       hit, wr_hit, rd_accept;
    logic       fifo_pop, fifo_full, fifo_empty;
    logic [9:0] fifo_head;
    logic       unused_addr_hi;

    assign unused_addr_hi = ^bus_address[15:8];

    assign hit    = io_hit(bus_address[7:0], IO_BASE);
    assign wr_hit = bus_io_write & hit;
    // A simultaneous write wins; a read during a pending/in-flight read is dropped.
    assign rd_accept = bus_io_read & hit & ~bus_io_write & ~pend_q;

    ip_vdp_bridge_fifo u_fifo (
        .clk       (clk),
        .n_reset   (n_reset),
        .push      (wr_hit),
        .push_data ({bus_address[1:0], bus_write_data}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        wrt_d       = wrt_q;
        address_d   = address_q;
        wdata_d     = wdata_q;
        ready_d     = 1'b0;
        rd_data_d   = rd_data_q;
        pend_d      = pend_q | rd_accept;
        pend_addr_d = rd_accept ? bus_address[1:0] : pend_addr_q;
        fifo_pop    = 1'b0;

        case (state_q)
            ST_WAIT_ACK: begin
                if (ack) begin
                    req_d   = 1'b0;
                    state_d = ST_GAP;
                    if (!wrt_q) begin
                        ready_d   = 1'b1;
                        rd_data_d = rdata;
                        pend_d    = 1'b0;
                    end
                end
            end
            // GAP is the mandatory req-low cycle; its closing edge may already
            // launch the next access, giving a one-cycle minimum gap.
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                if (!initial_busy) begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        address_d = fifo_head[9:8];
                        wdata_d   = fifo_head[7:0];
                        wrt_d     = 1'b1;
                        req_d     = 1'b1;
                        state_d   = ST_WAIT_ACK;
                    end else if (pend_q || rd_accept) begin
                        address_d = pend_q ? pend_addr_q : bus_address[1:0];
                        wrt_d     = 1'b0;
                        req_d     = 1'b1;
                        state_d   = ST_WAIT_ACK;
                    end
                end
            end
        endcase

        ovf_d = ovf_q | (wr_hit & fifo_full & ~fifo_pop);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= ST_IDLE;
            req_q       <= 1'b0;
            wrt_q       <= 1'b0;
            address_q   <= 2'd0;
            wdata_q     <= 8'h00;
            ready_q     <= 1'b0;
            rd_data_q   <= 8'hFF;
            ovf_q       <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            wrt_q       <= wrt_d;
            address_q   <= address_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            rd_data_q   <= rd_data_d;
            ovf_q       <= ovf_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    assign req            = req_q;
    assign wrt            = wrt_q;
    assign address        = address_q;
    assign wdata          = wdata_q;
    assign bus_read_ready = ready_q;
    assign bus_read_data  = rd_data_q;
    assign fifo_overflow  = ovf_q;

endmodule
